seq_muldiv_unit: RTL and testbench
==================================

Name: seq_muldiv_unit

Overview:
Iterative unsigned multiply/divide unit for the ALU datapath, parametrised in operand width. It extends the shift-by-2 and ripple add/subtract operators to full W x W multiplication (shift-add) and W / W division (restoring, trial subtract with borrow). It uses a start/done handshake and computes one bit per clock.

Parameters:
WIDTH, 8, operand width W in bits; legal range 2..32.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  input  1  system clock, all state changes on rising edge.
reset  input  1  synchronous reset, active-high.
start  input  1  request; sampled only when busy=0.
op  input  1  0 = multiply, 1 = divide; captured with start.
a  input  WIDTH  multiplicand / dividend; captured with start.
b  input  WIDTH  multiplier / divisor; captured with start.
busy  output  1  high in RUN and DONE states.
done  output  1  one-cycle pulse; results valid.
result_hi  output  WIDTH  mul: product[2W-1:W]; div: remainder.
result_lo  output  WIDTH  mul: product[W-1:0]; div: quotient.
div_by_zero  output  1  set with done when op=1 and b=0.

Behaviour:
- Clock is clk. Reset is synchronous and active-high on reset. Reset sets state IDLE, counter 0, and busy, done, result_hi, result_lo and div_by_zero to 0.
- Reset during RUN or DONE aborts the operation. No done pulse follows and the results clear to 0.
- States are IDLE, RUN and DONE. All outputs are registered.
- IDLE with start=1 is the accepting edge. It latches op, a and b and clears the counter.
  - If op=1 and b=0, the next state is DONE directly.
  - Otherwise the next state is RUN.
- start while busy=1, including the DONE cycle, is ignored. It is not queued.
- RUN performs one iteration per edge. After exactly W iterations it enters DONE. done is therefore high in the cycle beginning W+1 edges after the accepting edge.
- Divide-by-zero: done is high in the cycle right after the accepting edge, i.e. 1 edge.
- DONE lasts one cycle with done=1 and busy=1, then returns to IDLE. start can be accepted on the first IDLE cycle.
- result_hi, result_lo and div_by_zero update only on the edge that enters DONE. They hold until the next DONE entry or reset. div_by_zero clears on every normal completion.
- Multiply (shift-add): accumulator P[2W-1:0] = 0 and multiplier register M = b.
  - Each iteration: if M[0]=1, P[2W-1:W] takes the W-bit sum of P[2W-1:W] and a, with carry-out kept as bit W.
  - Then {carry, P} shifts right by 1 and M shifts right by 1.
  - The final P equals a*b exactly. No overflow is possible.
- Divide (restoring): R[W:0] = 0 and Q = a.
  - Each iteration: {R,Q} shifts left by 1.
  - Trial difference T = R - {0,b} in W+1 bits.
  - No borrow: R = T and Q[0] = 1. Borrow: R is unchanged and Q[0] = 0.
  - Final result: quotient = Q, remainder = R[W-1:0], with a = quotient*b + remainder and remainder < b.
- Divide by zero: result_lo = all ones, result_hi = a, div_by_zero = 1.
- Boundaries:
  - a=0 or b=0 on multiply gives 0 at the full W-cycle latency.
  - a<b on divide gives quotient 0 and remainder a.
  - a=b gives quotient 1 and remainder 0.
  - start held high continuously starts a new operation on every IDLE cycle.

Test Plan:
- W=8, reset, then mul a=13 b=11 -> done exactly 9 edges after accept; hi=0x00, lo=0x8F; busy high during those cycles.
- W=8, mul a=0xFF b=0xFF -> hi=0xFE, lo=0x01, div_by_zero=0. Also cover a=0x80 b=0x02 -> hi=0x01, lo=0x00.
- W=8, div a=200 b=7 -> lo=0x1C, hi=0x04. div a=5 b=9 -> lo=0x00, hi=0x05. div a=0x37 b=0x37 -> lo=0x01, hi=0x00.
- W=8, div a=0x2A b=0 -> done 1 edge after accept; lo=0xFF, hi=0x2A, div_by_zero=1. A following mul 3*4 -> lo=0x0C, div_by_zero=0.
- start pulsed with new operands mid-RUN and in the DONE cycle -> ignored; results match the original operands. Back-to-back start in the first IDLE cycle is accepted.
- reset asserted 4 cycles into a mul -> next cycle busy=0, done=0, results=0; no done pulse later. A fresh op after reset completes correctly.

Source files
------------

// File: rtl/seq_muldiv_unit.sv
// Iterative unsigned W x W multiply (shift-add) and W / W divide (restoring),
// one bit per clock, with a start/done handshake and registered outputs.
module seq_muldiv_unit #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_hi,
  output logic [WIDTH-1:0] result_lo,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_next;
  logic               busy_next, done_next;
  logic               accept, div_zero_c, last_iter;
  logic               op_r;
  logic [WIDTH-1:0]   a_r, b_r, m_r;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH:0]     acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic               div_borrow;
  logic [WIDTH:0]     iter_hi;
  logic [WIDTH-1:0]   iter_lo;

  assign accept     = (state == IDLE) && start;
  assign div_zero_c = op && (b == '0);
  assign last_iter  = (state == RUN) && (cnt == CNT_W'(WIDTH - 1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = div_zero_c ? DONE : RUN;
      RUN:     if (last_iter) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs follow the state being entered, so they register with it
  always_comb begin
    busy_next = 1'b0;
    done_next = 1'b0;
    busy_next = (state_next != IDLE);
    done_next = (state_next == DONE);
  end

  // One iteration: mul adds into the high half then shifts {carry,P} right;
  // div shifts {R,Q} left and keeps the trial difference when it does not borrow
  always_comb begin
    mul_sum    = {1'b0, acc_hi[WIDTH-1:0]} + (m_r[0] ? {1'b0, a_r} : '0);
    div_shift  = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
    div_diff   = div_shift - {1'b0, b_r};
    div_borrow = (div_shift < {1'b0, b_r});
    if (op_r) begin
      iter_hi = div_borrow ? div_shift : div_diff;
      iter_lo = {acc_lo[WIDTH-2:0], ~div_borrow};
    end else begin
      iter_hi = {1'b0, mul_sum[WIDTH:1]};
      iter_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      result_hi   <= '0;
      result_lo   <= '0;
      div_by_zero <= 1'b0;
      op_r        <= 1'b0;
      a_r         <= '0;
      b_r         <= '0;
      m_r         <= '0;
      cnt         <= '0;
      acc_hi      <= '0;
      acc_lo      <= '0;
    end else begin
      busy <= busy_next;
      done <= done_next;
      if (accept) begin
        op_r   <= op;
        a_r    <= a;
        b_r    <= b;
        m_r    <= b;
        cnt    <= '0;
        acc_hi <= '0;
        acc_lo <= op ? a : '0;
        if (div_zero_c) begin
          result_hi   <= a;
          result_lo   <= '1;
          div_by_zero <= 1'b1;
        end
      end else if (state == RUN) begin
        acc_hi <= iter_hi;
        acc_lo <= iter_lo;
        m_r    <= m_r >> 1;
        cnt    <= cnt + CNT_W'(1);
        if (last_iter) begin
          result_hi   <= iter_hi[WIDTH-1:0];
          result_lo   <= iter_lo;
          div_by_zero <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_muldiv_unit.sv
// Directed and random checks of seq_muldiv_unit against an arithmetic model.
module tb_seq_muldiv_unit;

  localparam int unsigned W = 8;

  logic         clk, reset, start, op;
  logic [W-1:0] a, b;
  logic         busy, done, div_by_zero;
  logic [W-1:0] result_hi, result_lo;

  int checks   = 0;
  int failures = 0;

  seq_muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result_hi(result_hi), .result_lo(result_lo),
    .div_by_zero(div_by_zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns {div_by_zero, hi, lo} from plain integer arithmetic
  function automatic logic [2*W:0] model(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
    int unsigned p;
    if (!o) begin
      p = int'(x) * int'(y);
      return {1'b0, p[2*W-1:0]};
    end
    if (y == '0) return {1'b1, x, {W{1'b1}}};
    p = int'(x) / int'(y);
    return {1'b0, W'(int'(x) % int'(y)), W'(p)};
  endfunction

  // inject: 0 none, 1 start pulse mid-RUN, 2 start pulse during DONE
  task automatic do_op(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input int inject, input string tag);
    logic [2*W:0] e;
    int edges;
    int lat;
    bit busy_low;
    e   = model(o, x, y);
    lat = (o && y == '0) ? 1 : W + 1;
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    edges = 1;
    busy_low = 1'b0;
    while (!done && edges < 40) begin
      if (!busy) busy_low = 1'b1;
      start = (inject == 1 && edges == 3);
      if (start) begin op = ~o; a = ~x; b = y + 8'd1; end
      @(posedge clk); #1;
      edges++;
    end
    start = 1'b0;
    chk({tag, "_latency"}, 32'(edges), 32'(lat));
    chk({tag, "_busy_run"}, 32'(busy_low), 32'd0);
    chk({tag, "_busy_done"}, 32'(busy), 32'd1);
    chk({tag, "_lo"}, 32'(result_lo), 32'(e[W-1:0]));
    chk({tag, "_hi"}, 32'(result_hi), 32'(e[2*W-1:W]));
    chk({tag, "_dbz"}, 32'(div_by_zero), 32'(e[2*W]));
    if (inject == 2) begin
      start = 1'b1; op = ~o; a = ~x; b = 8'h01;
    end
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    chk({tag, "_hold"}, 32'({result_hi, result_lo}), 32'(e[2*W-1:0]));
  endtask

  initial begin
    bit seen;
    logic         ro;
    logic [W-1:0] ra, rb;
    reset = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_hi", 32'(result_hi), 32'd0);
    chk("rst_lo", 32'(result_lo), 32'd0);
    chk("rst_dbz", 32'(div_by_zero), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    do_op(1'b0, 8'd13, 8'd11, 0, "mul_13x11");
    do_op(1'b0, 8'hFF, 8'hFF, 0, "mul_ffxff");
    do_op(1'b0, 8'h80, 8'h02, 0, "mul_80x02");
    do_op(1'b0, 8'h00, 8'h5A, 0, "mul_a0");
    do_op(1'b0, 8'h77, 8'h00, 0, "mul_b0");
    do_op(1'b1, 8'd200, 8'd7, 0, "div_200_7");
    do_op(1'b1, 8'd5, 8'd9, 0, "div_5_9");
    do_op(1'b1, 8'h37, 8'h37, 0, "div_eq");
    do_op(1'b1, 8'h2A, 8'h00, 0, "div_by0");
    do_op(1'b0, 8'd3, 8'd4, 0, "mul_after_div0");
    do_op(1'b1, 8'hFF, 8'h01, 0, "div_ff_1");
    do_op(1'b0, 8'd13, 8'd11, 1, "ign_midrun");
    do_op(1'b1, 8'd200, 8'd7, 2, "ign_done");
    do_op(1'b1, 8'h99, 8'h00, 2, "ign_done_div0");

    // Reset four cycles into a multiply aborts it
    op = 1'b0; a = 8'd13; b = 8'd11; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_hi", 32'(result_hi), 32'd0);
    chk("abort_lo", 32'(result_lo), 32'd0);
    chk("abort_dbz", 32'(div_by_zero), 32'd0);
    reset = 1'b0;
    seen = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1'b1;
    end
    chk("abort_no_done", 32'(seen), 32'd0);
    do_op(1'b0, 8'd21, 8'd10, 0, "mul_after_abort");

    for (int i = 0; i < 40; i++) begin
      ro = 1'($urandom);
      ra = W'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      do_op(ro, ra, rb, 0, $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
